// File: rtl/fs_rate_pkg.sv
// Shared types, constants and helpers for the symbol-rate strobe controller.
// Optional window monitor is enabled by defining FS_RATE_MON_EN.
package fs_rate_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_WAIT_EDGE = 3'd2,
    ST_LOAD      = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_RUN       = 3'd5,
    ST_ERR       = 3'd6
  } fs_state_t;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_CFG    = 2'd1;
  localparam logic [1:0] ERR_SETTLE = 2'd2;

  localparam int unsigned RST_CYC_DEF     = 2;
  localparam int unsigned TIMEOUT_CYC_DEF = 1000000;
  localparam int unsigned WIN_CYC_DEF     = 100000;

  // A config is usable only if 4*baud fits under freq, so generator pulses
  // always have idle cycles between them; the compare is done in 34 bits.
  function automatic logic fs_rate_cfg_ok(input logic [31:0] baud,
                                          input logic [31:0] freq);
    logic [33:0] baud_x4;
    baud_x4 = {2'b00, baud} << 2;
    return (baud != 32'd0) && (freq != 32'd0) && (baud_x4 <= {2'b00, freq});
  endfunction

  function automatic logic [31:0] fs_sat_inc(input logic [31:0] value,
                                             input logic        inc);
    if (inc && (value != 32'hFFFF_FFFF)) return value + 32'd1;
    return value;
  endfunction

endpackage

// File: rtl/fs_rate_win_mon.sv
// Strobe-rate monitor: counts strobes over a fixed window while the
// controller is running and latches the total at the end of each window.
module fs_rate_win_mon
  import fs_rate_pkg::*;
#(
  parameter int unsigned WIN_CYC = WIN_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        active,
  input  logic        clear,
  input  logic        strobe,
  output logic [31:0] strobe_cnt
);

  localparam logic [31:0] WIN_LAST = 32'(WIN_CYC - 1);

  logic [31:0] win;
  logic [31:0] acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win        <= '0;
      acc        <= '0;
      strobe_cnt <= '0;
    end else begin
      if (clear) strobe_cnt <= '0;
      // Outside RUN the window is held at its start so it restarts cleanly.
      if (!active) begin
        win <= '0;
        acc <= '0;
      end else if (win >= WIN_LAST) begin
        win        <= '0;
        acc        <= '0;
        strobe_cnt <= fs_sat_inc(acc, strobe);
      end else begin
        win <= win + 32'd1;
        acc <= fs_sat_inc(acc, strobe);
      end
    end
  end

endmodule

// File: rtl/fs_rate_ctrl.sv
// Run-time rate controller for the fs_en strobe generator: validates new
// configs and applies them on a symbol boundary. Monitor: FS_RATE_MON_EN.
module fs_rate_ctrl
  import fs_rate_pkg::*;
#(
  parameter int unsigned RST_CYC     = RST_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned WIN_CYC     = WIN_CYC_DEF
) (
  input  logic        sys_clk,
  input  logic        glb_rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_baud,
  input  logic [31:0] cfg_freq,
  input  logic        fs_en_in,
  output logic        gen_rst_n,
  output logic [31:0] gen_baud,
  output logic [31:0] gen_freq,
  output logic        run,
  output logic        lock,
  output logic        cfg_err,
  output logic [1:0]  err_code,
  output logic [31:0] strobe_cnt
);

  localparam logic [31:0] RST_LAST = 32'(RST_CYC - 1);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYC - 1);

  fs_state_t   state;
  logic [31:0] shadow_baud;
  logic [31:0] shadow_freq;
  logic        from_run;
  logic [31:0] cnt;

  logic cfg_ok;
  logic timeout_hit;
  logic load_go;

  assign cfg_ok      = fs_rate_cfg_ok(shadow_baud, shadow_freq);
  assign timeout_hit = (cnt >= TO_LAST);
  // Entry into LOAD: straight from CHECK when idle/errored, or on the next
  // symbol boundary (or timeout) when replacing a running configuration.
  assign load_go = ((state == ST_CHECK) && cfg_ok && !from_run) ||
                   ((state == ST_WAIT_EDGE) && (fs_en_in || timeout_hit));

  always_ff @(posedge sys_clk) begin
    if (!glb_rst_n) begin
      state       <= ST_IDLE;
      shadow_baud <= '0;
      shadow_freq <= '0;
      from_run    <= 1'b0;
      cnt         <= '0;
      cfg_ready   <= 1'b1;
      gen_rst_n   <= 1'b0;
      gen_baud    <= '0;
      gen_freq    <= '0;
      run         <= 1'b0;
      lock        <= 1'b0;
      cfg_err     <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      case (state)
        ST_IDLE, ST_RUN, ST_ERR: begin
          if (cfg_valid) begin
            shadow_baud <= cfg_baud;
            shadow_freq <= cfg_freq;
            from_run    <= (state == ST_RUN);
            state       <= ST_CHECK;
            cfg_ready   <= 1'b0;
            cnt         <= '0;
          end
        end
        ST_CHECK: begin
          cnt <= '0;
          if (!cfg_ok) begin
            // Leave the generator untouched so an old config keeps running.
            state     <= ST_ERR;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b1;
            err_code  <= ERR_CFG;
          end else begin
            cfg_err  <= 1'b0;
            err_code <= ERR_NONE;
            if (from_run) state <= ST_WAIT_EDGE;
          end
        end
        ST_WAIT_EDGE: begin
          if (!load_go) cnt <= cnt + 32'd1;
        end
        ST_LOAD: begin
          if (cnt >= RST_LAST) begin
            state     <= ST_SETTLE;
            gen_rst_n <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_SETTLE: begin
          if (fs_en_in) begin
            state     <= ST_RUN;
            run       <= 1'b1;
            lock      <= 1'b1;
            cfg_ready <= 1'b1;
            cnt       <= '0;
          end else if (timeout_hit) begin
            state     <= ST_ERR;
            gen_rst_n <= 1'b0;
            cfg_err   <= 1'b1;
            err_code  <= ERR_SETTLE;
            cfg_ready <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cfg_ready <= 1'b1;
          cnt       <= '0;
        end
      endcase

      if (load_go) begin
        state     <= ST_LOAD;
        gen_baud  <= shadow_baud;
        gen_freq  <= shadow_freq;
        gen_rst_n <= 1'b0;
        run       <= 1'b0;
        lock      <= 1'b0;
        cnt       <= '0;
      end
    end
  end

`ifdef FS_RATE_MON_EN
  logic in_run;
  assign in_run = (state == ST_RUN);

  fs_rate_win_mon #(
    .WIN_CYC (WIN_CYC)
  ) u_win_mon (
    .clk        (sys_clk),
    .rst_n      (glb_rst_n),
    .active     (in_run),
    .clear      (load_go),
    .strobe     (fs_en_in),
    .strobe_cnt (strobe_cnt)
  );
`else
  assign strobe_cnt = '0;
  if (WIN_CYC == 0) begin : g_win_unused
  end
`endif

endmodule

// File: tb/tb_fs_rate_ctrl.sv
// Directed bench for fs_rate_ctrl with a behavioural strobe generator
// looped back (fs_en rate = 2*baud/freq per cycle).
module tb_fs_rate_ctrl;

  localparam int unsigned RST_CYC     = 2;
  localparam int unsigned TIMEOUT_CYC = 50;
  localparam int unsigned WIN_CYC     = 100;
`ifdef FS_RATE_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic        sys_clk;
  logic        glb_rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_baud;
  logic [31:0] cfg_freq;
  logic        fs_en_in;
  logic        gen_rst_n;
  logic [31:0] gen_baud;
  logic [31:0] gen_freq;
  logic        run;
  logic        lock;
  logic        cfg_err;
  logic [1:0]  err_code;
  logic [31:0] strobe_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  fs_rate_ctrl #(
    .RST_CYC     (RST_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .WIN_CYC     (WIN_CYC)
  ) dut (
    .sys_clk    (sys_clk),
    .glb_rst_n  (glb_rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_baud   (cfg_baud),
    .cfg_freq   (cfg_freq),
    .fs_en_in   (fs_en_in),
    .gen_rst_n  (gen_rst_n),
    .gen_baud   (gen_baud),
    .gen_freq   (gen_freq),
    .run        (run),
    .lock       (lock),
    .cfg_err    (cfg_err),
    .err_code   (err_code),
    .strobe_cnt (strobe_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Behavioural generator: accumulate 2*baud, strobe on wrap past freq.
  logic [33:0] gen_acc;
  logic        gen_fs;
  logic        fs_loop;
  always @(posedge sys_clk) begin
    if (!gen_rst_n) begin
      gen_acc <= '0;
      gen_fs  <= 1'b0;
    end else if (gen_acc + {1'b0, gen_baud, 1'b0} >= {2'b00, gen_freq}) begin
      gen_acc <= gen_acc + {1'b0, gen_baud, 1'b0} - {2'b00, gen_freq};
      gen_fs  <= 1'b1;
    end else begin
      gen_acc <= gen_acc + {1'b0, gen_baud, 1'b0};
      gen_fs  <= 1'b0;
    end
  end
  assign fs_en_in = fs_loop & gen_fs;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h), want %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic do_reset();
    glb_rst_n = 1'b0;
    cfg_valid = 1'b0;
    tick();
    tick();
    glb_rst_n = 1'b1;
  endtask

  // Returns just after the accept edge (DUT is then in CHECK).
  task automatic offer(input logic [31:0] b, input logic [31:0] f);
    int waited = 0;
    while (!cfg_ready && waited < 300) begin
      tick();
      waited++;
    end
    check("offer_ready", {31'd0, cfg_ready}, 32'd1);
    cfg_baud  = b;
    cfg_freq  = f;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_lock(input string name);
    int waited = 0;
    while (!lock && waited < 100) begin
      tick();
      waited++;
    end
    check(name, {31'd0, lock}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] baud;
    logic [31:0] freq;
    logic        ok;
  } vec_t;
  vec_t vecs[9];

  initial begin
    int n;
    vecs[0] = '{32'd2500,       32'd10000,       1'b1};
    vecs[1] = '{32'd2501,       32'd10000,       1'b0};
    vecs[2] = '{32'd0,          32'd10000,       1'b0};
    vecs[3] = '{32'd1000,       32'd0,           1'b0};
    vecs[4] = '{32'd1,          32'd4,           1'b1};
    vecs[5] = '{32'd1,          32'd3,           1'b0};
    vecs[6] = '{32'h4000_0000,  32'hFFFF_FFFF,   1'b0};
    vecs[7] = '{32'h3FFF_FFFF,  32'hFFFF_FFFC,   1'b1};
    vecs[8] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,   1'b0};

    fs_loop   = 1'b0;
    cfg_valid = 1'b0;
    cfg_baud  = '0;
    cfg_freq  = '0;
    glb_rst_n = 1'b0;

    // Reset values
    do_reset();
    check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    check("rst_gen_rst_n", {31'd0, gen_rst_n}, 32'd0);
    check("rst_gen_baud", gen_baud, 32'd0);
    check("rst_gen_freq", gen_freq, 32'd0);
    check("rst_run", {31'd0, run}, 32'd0);
    check("rst_lock", {31'd0, lock}, 32'd0);
    check("rst_err", {29'd0, cfg_err, err_code}, 32'd0);
    check("rst_strobe_cnt", strobe_cnt, 32'd0);

    // Validity table, each applied from IDLE
    for (int i = 0; i < 9; i++) begin
      do_reset();
      offer(vecs[i].baud, vecs[i].freq);
      check("vec_check_ready", {31'd0, cfg_ready}, 32'd0);
      tick();
      check("vec_err_code", {30'd0, err_code}, vecs[i].ok ? 32'd0 : 32'd1);
      check("vec_cfg_err", {31'd0, cfg_err}, vecs[i].ok ? 32'd0 : 32'd1);
      check("vec_cfg_ready", {31'd0, cfg_ready}, vecs[i].ok ? 32'd0 : 32'd1);
      check("vec_gen_baud", gen_baud, vecs[i].ok ? vecs[i].baud : 32'd0);
      check("vec_gen_freq", gen_freq, vecs[i].ok ? vecs[i].freq : 32'd0);
      tick();
      tick();
      check("vec_gen_baud_late", gen_baud, vecs[i].ok ? vecs[i].baud : 32'd0);
      $display("vec %0d baud=%0d freq=%0d ok=%0b err_code=%0d", i, vecs[i].baud,
               vecs[i].freq, vecs[i].ok, err_code);
    end

    // A: first load with generator looped back
    do_reset();
    fs_loop = 1'b1;
    offer(32'd2500, 32'd10000);
    check("a_check_ready", {31'd0, cfg_ready}, 32'd0);
    tick();
    check("a_load1_rst", {31'd0, gen_rst_n}, 32'd0);
    check("a_load1_baud", gen_baud, 32'd2500);
    check("a_load1_freq", gen_freq, 32'd10000);
    tick();
    check("a_load2_rst", {31'd0, gen_rst_n}, 32'd0);
    tick();
    check("a_settle_rst", {31'd0, gen_rst_n}, 32'd1);
    check("a_settle_lock", {31'd0, lock}, 32'd0);
    wait_lock("a_lock");
    check("a_run", {31'd0, run}, 32'd1);
    check("a_ready", {31'd0, cfg_ready}, 32'd1);
    repeat (110) tick();
    check("a_strobe_cnt", strobe_cnt, MON ? 32'd50 : 32'd0);
    $display("seq A: lock=%0b run=%0b strobe_cnt=%0d", lock, run, strobe_cnt);

    // B: invalid config while running keeps old generator settings
    offer(32'd2501, 32'd10000);
    tick();
    check("b_cfg_err", {31'd0, cfg_err}, 32'd1);
    check("b_err_code", {30'd0, err_code}, 32'd1);
    check("b_gen_baud", gen_baud, 32'd2500);
    check("b_gen_rst_n", {31'd0, gen_rst_n}, 32'd1);
    check("b_run", {31'd0, run}, 32'd1);
    check("b_lock", {31'd0, lock}, 32'd1);
    check("b_ready", {31'd0, cfg_ready}, 32'd1);
    check("b_strobe_cnt", strobe_cnt, MON ? 32'd50 : 32'd0);
    $display("seq B: err_code=%0d gen_baud=%0d", err_code, gen_baud);

    // C: back to RUN, then retune on a symbol boundary
    offer(32'd2500, 32'd10000);
    wait_lock("c_relock");
    offer(32'd1000, 32'd10000);
    tick();
    check("c_err_cleared", {29'd0, cfg_err, err_code}, 32'd0);
    check("c_wait_run", {31'd0, run}, 32'd1);
    n = 0;
    while (!fs_en_in && n < 60) begin
      check("c_wait_no_load", {31'd0, gen_rst_n}, 32'd1);
      tick();
      n++;
    end
    check("c_edge_seen", {31'd0, fs_en_in}, 32'd1);
    check("c_pre_edge_baud", gen_baud, 32'd2500);
    tick();
    check("c_load_rst", {31'd0, gen_rst_n}, 32'd0);
    check("c_load_baud", gen_baud, 32'd1000);
    check("c_load_run", {31'd0, run}, 32'd0);
    check("c_load_strobe_cnt", strobe_cnt, 32'd0);
    wait_lock("c_lock");
    repeat (110) tick();
    check("c_strobe_cnt", strobe_cnt, MON ? 32'd20 : 32'd0);
    $display("seq C: gen_baud=%0d strobe_cnt=%0d", gen_baud, strobe_cnt);

    // D: settle timeout with no strobe
    do_reset();
    fs_loop = 1'b0;
    offer(32'd2500, 32'd10000);
    tick();
    tick();
    tick();
    n = 0;
    while (gen_rst_n && n < 200) begin
      n++;
      tick();
    end
    check("d_settle_cycles", n, 32'd50);
    check("d_err_code", {30'd0, err_code}, 32'd2);
    check("d_cfg_err", {31'd0, cfg_err}, 32'd1);
    check("d_lock", {31'd0, lock}, 32'd0);
    check("d_gen_rst_n", {31'd0, gen_rst_n}, 32'd0);
    check("d_ready", {31'd0, cfg_ready}, 32'd1);
    $display("seq D: settle cycles=%0d err_code=%0d", n, err_code);

    // E: reset asserted mid-SETTLE, cfg_valid ignored during reset
    do_reset();
    offer(32'd2500, 32'd10000);
    repeat (6) tick();
    check("e_in_settle", {31'd0, gen_rst_n}, 32'd1);
    glb_rst_n = 1'b0;
    cfg_valid = 1'b1;
    cfg_baud  = 32'd1000;
    cfg_freq  = 32'd10000;
    tick();
    check("e_gen_rst_n", {31'd0, gen_rst_n}, 32'd0);
    check("e_gen_baud", gen_baud, 32'd0);
    check("e_gen_freq", gen_freq, 32'd0);
    check("e_ready", {31'd0, cfg_ready}, 32'd1);
    check("e_flags", {28'd0, run, lock, cfg_err, |err_code}, 32'd0);
    tick();
    glb_rst_n = 1'b1;
    cfg_valid = 1'b0;
    tick();
    check("e_idle_ready", {31'd0, cfg_ready}, 32'd1);
    check("e_idle_baud", gen_baud, 32'd0);
    $display("seq E: cfg_ready=%0b gen_baud=%0d", cfg_ready, gen_baud);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fs_rate_ctrl.md
Name: fs_rate_ctrl

Overview:
Run-time controller for the symbol-rate strobe generator (the baud/system-frequency accumulator producing fs_en). Accepts new rate configurations over a valid/ready handshake and validates them. Applies each accepted configuration only on a symbol boundary by resetting and reloading the generator, then confirms the first strobe and reports lock. Sits between the host register bank and the strobe generator; the DVB-S2 datapath consumes the generator's fs_en directly.

Parameters:
RST_CYC, 2, cycles gen_rst_n is held low during LOAD (min 1).
TIMEOUT_CYC, 1000000, max cycles to wait for a strobe in WAIT_EDGE or SETTLE.
WIN_CYC, 100000, measurement window length in cycles (FS_RATE_MON_EN only).

Ports:
sys_clk  in  1  system clock.
glb_rst_n  in  1  synchronous active-low reset.
cfg_valid  in  1  new configuration offered.
cfg_ready  out  1  controller can accept a configuration.
cfg_baud  in  32  requested SYS_Baud_Num.
cfg_freq  in  32  requested SYS_Freq_Num.
fs_en_in  in  1  strobe returned from the generator.
gen_rst_n  out  1  drives the generator's glb_rst_n.
gen_baud  out  32  drives the generator's SYS_Baud_Num.
gen_freq  out  32  drives the generator's SYS_Freq_Num.
run  out  1  generator is running a validated configuration.
lock  out  1  first strobe seen after the last load.
cfg_err  out  1  sticky error flag.
err_code  out  2  0 none, 1 invalid config, 2 settle timeout.
strobe_cnt  out  32  strobes counted in the last complete window.

Behaviour:
- Clock and reset: single clock sys_clk; reset glb_rst_n is synchronous, active-low.
- Reset values: state IDLE, cfg_ready=1, gen_rst_n=0, gen_baud=0, gen_freq=0, run=0, lock=0, cfg_err=0, err_code=0, strobe_cnt=0, all counters 0.
- States: IDLE, CHECK, WAIT_EDGE, LOAD, SETTLE, RUN, ERR.
- Handshake:
  - cfg_ready=1 only in IDLE, RUN and ERR.
  - A transfer occurs when cfg_valid&&cfg_ready. cfg_baud and cfg_freq are captured into shadow registers and the state goes to CHECK next cycle.
  - cfg_valid in any other state is ignored (not captured).
- CHECK (1 cycle):
  - Config is valid iff baud!=0, freq!=0 and {2'b00,baud}<<2 <= {2'b00,freq} (34-bit compare). This guarantees gaps between generator pulses so every overflow yields one fs_en.
  - Invalid: go to ERR with cfg_err=1, err_code=1. gen_* and gen_rst_n are unchanged, so a running generator keeps running on its old config; run and lock keep their values.
  - Valid and previous state RUN: go to WAIT_EDGE.
  - Valid otherwise: go to LOAD.
  - A valid accept clears cfg_err and err_code.
- WAIT_EDGE:
  - Wait for fs_en_in=1; LOAD starts the following cycle.
  - If TIMEOUT_CYC cycles elapse without a strobe, go to LOAD anyway (not an error).
  - run stays 1.
- LOAD:
  - On entry cycle: gen_baud and gen_freq take the shadow values; gen_rst_n=0; run=0; lock=0.
  - Lasts exactly RST_CYC cycles, then SETTLE.
  - fs_en_in is ignored.
- SETTLE:
  - gen_rst_n=1.
  - First fs_en_in=1 → RUN, lock=1, run=1 on the next cycle.
  - TIMEOUT_CYC cycles without a strobe → ERR with cfg_err=1, err_code=2, gen_rst_n=0.
- RUN: gen_rst_n=1, run=1, lock=1. An accepted config enters CHECK.
- ERR:
  - Outputs hold.
  - gen_rst_n=0 after a settle timeout; unchanged after an invalid config.
  - Leaves only on a new accepted config.
- Timeout counters: 32-bit; cleared on every state entry; compare uses >= TIMEOUT_CYC-1.
- Reset mid-operation: all state returns to reset values on the next edge. There is no partial apply: gen_* revert to 0.

Optional Feature:
FS_RATE_MON_EN
- Defined:
  - Window counter counts 0..WIN_CYC-1, free-running only while in RUN; it restarts at 0 on RUN entry.
  - Strobes counted during the window (saturating at 2^32-1) are latched into strobe_cnt on the last window cycle, with the counter then cleared.
  - A strobe coincident with the last window cycle is included in the latched value.
  - strobe_cnt is cleared on LOAD entry.
- Undefined: strobe_cnt tied to 0; WIN_CYC is unused; no monitor logic.

Decomposition:
- Package fs_rate_pkg:
  - state enum;
  - err_code constants ERR_NONE/ERR_CFG/ERR_SETTLE;
  - default constants for RST_CYC, TIMEOUT_CYC and WIN_CYC;
  - the 34-bit validity compare as a function.
- One sub-module, fs_rate_win_mon: window counter plus strobe counter, instantiated only under FS_RATE_MON_EN.

Test Plan:
- Reset, then cfg 2500/10000 with a real generator looped back. Expect:
  - CHECK 1 cycle, then gen_rst_n=0 for 2 cycles with gen_baud=2500 and gen_freq=10000;
  - SETTLE, first fs_en_in, then lock=1, run=1;
  - with WIN_CYC=100, strobe_cnt=50.
- From RUN, cfg 2501/10000. Expect cfg_err=1, err_code=1; gen_baud stays 2500; gen_rst_n stays 1; strobe_cnt stays 50.
- From RUN, cfg 1000/10000. Expect:
  - no LOAD until the next fs_en_in; gen_rst_n falls the cycle after that pulse;
  - err cleared; strobe_cnt=20 after a full window.
- fs_en_in tied 0, TIMEOUT_CYC=50, cfg 2500/10000. Expect exactly 50 SETTLE cycles, then ERR with err_code=2, lock=0, gen_rst_n=0, cfg_ready=1.
- cfg baud=0 or freq=0. Expect err_code=1 and no LOAD.
- glb_rst_n pulsed low mid-SETTLE. Expect all outputs at reset values on the next edge, state IDLE, and cfg_valid ignored while reset is low.
